rr_mux16_arbiter: RTL and testbench
===================================

RR_MUX16_ARBITER -- requirements
Module: rr_mux16_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, max beats per grant before forced rotation (range 1..15).
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req  input  16  per-requester request, bit k = requester k.
REQ-005 data_in  input  16  per-requester data bit, bit k = requester k.
REQ-006 gnt  output  16  one-hot grant, registered.
REQ-007 mux_se  output  4  select code in mux16x1 se[3:0] encoding, registered.
REQ-008 out_valid  output  1  beat valid to downstream.
REQ-009 out_data  output  1  selected data bit, data_in[granted index].
REQ-010 out_ready  input  1  downstream accepts beat.

Function
REQ-011 States SHALL be IDLE and XFER only.
REQ-012 Channel index k SHALL map to mux_se as k = 8*se[2] + 4*se[3] + 2*se[0] + se[1]; k=1 -> se=4'b0010, k=4 -> 4'b1000, k=15 -> 4'b1111.
REQ-013 Winner SHALL be the first set req bit at or above rotating pointer ptr, wrapping 15 -> 0.
REQ-014 IDLE, req != 0 at edge N: gnt, mux_se loaded with winner, state XFER at N+1 (one-cycle request-to-grant latency).
REQ-015 IDLE, req == 0: gnt = 0, out_valid = 0, mux_se and ptr held.
REQ-016 XFER: out_valid = 1, gnt one-hot; out_data combinational from data_in through mux16x1 driven by mux_se.
REQ-017 Beat completes on out_valid & out_ready; beat counter increments on each beat.
REQ-018 out_ready low in XFER: gnt, mux_se, counter held; req changes ignored until a beat completes.
REQ-019 Release after beat when req[granted] is low at that edge, or when counter reaches MAX_BURST.
REQ-020 On release ptr SHALL become granted index + 1 mod 16, counter cleared.
REQ-021 On release with any req bit set (re-evaluated with new ptr, including the released requester) the next grant SHALL load on the same edge: back-to-back, no idle cycle.
REQ-022 On release with req == 0: state IDLE, gnt = 0, out_valid = 0 next cycle.
REQ-023 Sole requester holding req SHALL be regranted after MAX_BURST beats, counter restarts at 0.
REQ-024 gnt SHALL never have more than one bit set; gnt != 0 iff state XFER.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, gnt = 0, mux_se = 0, out_valid = 0, ptr = 0, counter = 0.
REQ-026 Reset mid-burst SHALL drop the beat in flight; first grant after release follows REQ-014 from ptr = 0.
REQ-027 Deassertion of rst_n is synchronized externally; block is not required to be glitch-safe on release.

Structure
REQ-028 State encoding, select-map helper constants and MAX_BURST default SHALL live in shared package mux_ctrl_pkg.
REQ-029 One sub-module instance: mux16x1, inputs data_in[0..15], se = mux_se, output out_data.
REQ-030 Arbiter priority logic, pointer, counter and FSM SHALL be in rr_mux16_arbiter itself.

Verification
REQ-031 Reset then req = 16'h0002, out_ready = 1 -> cycle 1 gnt = 16'h0002, mux_se = 4'b0010, out_valid = 1, out_data = data_in[1].
REQ-032 req = 16'h8001, ptr = 0, req held, out_ready = 1, MAX_BURST = 4 -> 4 beats to 0, then 4 to 15, then 0; no idle cycle between grants.
REQ-033 Grant to 15 with req[15] dropped at its first beat, req[3] set -> next gnt = 16'h0008, ptr wraps 0 -> index 3.
REQ-034 out_ready held low 10 cycles in XFER, req toggling -> gnt, mux_se, out_data stable; counter unchanged.
REQ-035 rst_n pulsed low mid-burst on requester 7 -> all outputs 0 during low; after release, req = 16'h0180 -> gnt = 16'h0080.

Source files
------------

// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the round-robin 16:1 mux arbiter: FSM states, sizes
// and the helpers that translate between a channel index and the mux16x1 select code.
package mux_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    localparam int NUM_CH            = 16;
    localparam int SEL_W             = 4;
    localparam int CNT_W             = 4;
    localparam int MAX_BURST_DEFAULT = 4;

    // The mux16x1 select bits are not in binary order: k = 8*se[2] + 4*se[3] + 2*se[0] + se[1].
    function automatic logic [SEL_W-1:0] idx_to_se(input logic [SEL_W-1:0] k);
        return {k[2], k[3], k[0], k[1]};
    endfunction

    function automatic logic [SEL_W-1:0] se_to_idx(input logic [SEL_W-1:0] se);
        return {se[2], se[3], se[0], se[1]};
    endfunction

endpackage

// File: rtl/mux16x1.sv
// 16:1 single-bit multiplexer using the scrambled se[3:0] select encoding.
module mux16x1
    import mux_ctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] data_in,
    input  logic [SEL_W-1:0]  se,
    output logic              out_data
);

    assign out_data = data_in[se_to_idx(se)];

endmodule

// File: rtl/rr_mux16_arbiter.sv
// Round-robin arbiter over 16 requesters with burst limiting; the granted
// requester's data bit is steered to the output through a mux16x1 instance.
module rr_mux16_arbiter
    import mux_ctrl_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] data_in,
    input  logic              out_ready,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  mux_se,
    output logic              out_valid,
    output logic              out_data
);

    localparam logic [CNT_W-1:0] BURST_LIMIT = CNT_W'(MAX_BURST);

    state_t             state;
    state_t             state_n;
    logic [NUM_CH-1:0]  gnt_n;
    logic [SEL_W-1:0]   se_n;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   ptr_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [CNT_W-1:0]   cnt_inc;
    logic [SEL_W-1:0]   cur_idx;
    logic [SEL_W-1:0]   search_base;
    logic [SEL_W-1:0]   cand;
    logic [SEL_W-1:0]   win_idx;
    logic               win_found;
    logic               release_now;

    assign cur_idx     = se_to_idx(mux_se);
    assign cnt_inc     = cnt + CNT_W'(1);
    assign release_now = !req[cur_idx] || (cnt_inc == BURST_LIMIT);

    // On release the search starts just past the current owner, so it is
    // already the rotated pointer and a back-to-back grant needs no extra cycle.
    assign search_base = (state == XFER) ? cur_idx + SEL_W'(1) : ptr;

    always_comb begin
        win_found = 1'b0;
        win_idx   = search_base;
        cand      = search_base;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = search_base + SEL_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        se_n    = mux_se;
        ptr_n   = ptr;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_n = XFER;
                    gnt_n   = NUM_CH'(1) << win_idx;
                    se_n    = idx_to_se(win_idx);
                end else begin
                    gnt_n   = '0;
                end
            end
            XFER: begin
                if (out_ready) begin
                    if (release_now) begin
                        ptr_n = cur_idx + SEL_W'(1);
                        cnt_n = '0;
                        if (win_found) begin
                            gnt_n = NUM_CH'(1) << win_idx;
                            se_n  = idx_to_se(win_idx);
                        end else begin
                            state_n = IDLE;
                            gnt_n   = '0;
                        end
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        out_valid = (state == XFER);
    end

    // mux_se and ptr keep their values through IDLE so the pointer survives idle gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt    <= '0;
            mux_se <= '0;
            ptr    <= '0;
            cnt    <= '0;
        end else begin
            gnt    <= gnt_n;
            mux_se <= se_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
        end
    end

    mux16x1 u_mux (
        .data_in  (data_in),
        .se       (mux_se),
        .out_data (out_data)
    );

endmodule

// File: tb/tb_rr_mux16_arbiter.sv
// Bench for rr_mux16_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level round-robin model.
module tb_rr_mux16_arbiter;

    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic [15:0] data_in;
    logic        out_ready;
    logic [15:0] gnt;
    logic [3:0]  mux_se;
    logic        out_valid;
    logic        out_data;

    int checks = 0;
    int errors = 0;

    bit m_busy;
    int m_owner;
    int m_last;
    int m_ptr;
    int m_beats;

    logic [15:0] exp032 [10];

    rr_mux16_arbiter #(.MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .out_ready (out_ready),
        .gnt       (gnt),
        .mux_se    (mux_se),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] se_of(input int k);
        logic [3:0] v;
        for (int s = 0; s < 16; s++) begin
            v = 4'(s);
            if (8 * int'(v[2]) + 4 * int'(v[3]) + 2 * int'(v[0]) + int'(v[1]) == k) return v;
        end
        return 4'h0;
    endfunction

    function automatic int winner(input logic [15:0] r, input int p);
        for (int i = 0; i < 16; i++) begin
            if (r[(p + i) % 16]) return (p + i) % 16;
        end
        return -1;
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_last  = 0;
        m_ptr   = 0;
        m_beats = 0;
    endtask

    task automatic modelClock();
        if (!m_busy) begin
            if (req != 16'h0) begin
                m_owner = winner(req, m_ptr);
                m_last  = m_owner;
                m_busy  = 1'b1;
            end
        end else if (out_ready) begin
            m_beats++;
            if (!req[m_owner] || m_beats == MAXB) begin
                m_ptr   = (m_owner + 1) % 16;
                m_beats = 0;
                if (req != 16'h0) begin
                    m_owner = winner(req, m_ptr);
                    m_last  = m_owner;
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        logic [15:0] exp_gnt;
        exp_gnt = m_busy ? (16'h0001 << m_owner) : 16'h0000;
        checkEq("gnt", 32'(gnt), 32'(exp_gnt));
        checkEq("mux_se", 32'(mux_se), 32'(se_of(m_last)));
        checkEq("out_valid", 32'(out_valid), 32'(m_busy));
        checkEq("out_data", 32'(out_data), 32'(data_in[m_last]));
        checkEq("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic applyStimulus(input logic [15:0] r, input logic [15:0] d, input logic rdy);
        @(negedge clk);
        req       = r;
        data_in   = d;
        out_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) modelClock();
    endtask

    task automatic cycle(input logic [15:0] r, input logic [15:0] d, input logic rdy);
        applyStimulus(r, d, rdy);
        checkOutput();
        tick();
    endtask

    // Reset is asserted between clock edges to exercise its asynchronous path.
    task automatic doReset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        req   = 16'h0;
        #1;
        modelReset();
        checkOutput();
        checkEq("rst_gnt", 32'(gnt), 32'h0);
        checkEq("rst_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #1;
        checkOutput();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        modelClock();
    endtask

    initial begin
        logic [15:0] r;
        logic [15:0] d;
        rst_n     = 1'b0;
        req       = 16'h0;
        data_in   = 16'h0;
        out_ready = 1'b0;
        modelReset();
        doReset();

        $display("[TB] single requester grant latency");
        cycle(16'h0002, 16'h0002, 1'b1);
        applyStimulus(16'h0002, 16'h0002, 1'b1);
        checkOutput();
        checkEq("r031_gnt", 32'(gnt), 32'h0002);
        checkEq("r031_se", 32'(mux_se), 32'b0010);
        checkEq("r031_valid", 32'(out_valid), 32'h1);
        checkEq("r031_data", 32'(out_data), 32'h1);
        tick();

        $display("[TB] two requesters, burst rotation");
        doReset();
        exp032 = '{16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0001,
                   16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h0001};
        for (int c = 0; c < 10; c++) begin
            applyStimulus(16'h8001, 16'($urandom), 1'b1);
            checkOutput();
            checkEq("r032_gnt", 32'(gnt), 32'(exp032[c]));
            tick();
        end

        $display("[TB] pointer wrap after early release");
        doReset();
        cycle(16'h8000, 16'h8000, 1'b1);
        applyStimulus(16'h0008, 16'h8000, 1'b1);
        checkOutput();
        checkEq("r033_gnt15", 32'(gnt), 32'h8000);
        tick();
        applyStimulus(16'h0008, 16'h0008, 1'b1);
        checkOutput();
        checkEq("r033_gnt3", 32'(gnt), 32'h0008);
        checkEq("r033_se3", 32'(mux_se), 32'b0011);
        tick();

        $display("[TB] stalled downstream");
        for (int c = 0; c < 10; c++) begin
            applyStimulus(16'($urandom), 16'h0008, 1'b0);
            checkOutput();
            checkEq("r034_gnt", 32'(gnt), 32'h0008);
            checkEq("r034_se", 32'(mux_se), 32'b0011);
            checkEq("r034_data", 32'(out_data), 32'h1);
            tick();
        end
        for (int c = 0; c < 6; c++) cycle(16'h0008, 16'($urandom), 1'b1);

        $display("[TB] reset mid-burst");
        doReset();
        cycle(16'h0080, 16'h0080, 1'b1);
        cycle(16'h0080, 16'h0080, 1'b1);
        doReset();
        cycle(16'h0180, 16'h0180, 1'b1);
        applyStimulus(16'h0180, 16'h0080, 1'b1);
        checkOutput();
        checkEq("r035_gnt", 32'(gnt), 32'h0080);
        tick();

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 149) == 0) begin
                doReset();
            end else begin
                case ($urandom_range(0, 3))
                    0:       r = 16'h0;
                    1:       r = 16'(1 << $urandom_range(0, 15));
                    default: r = 16'($urandom) & 16'($urandom);
                endcase
                d = 16'($urandom);
                cycle(r, d, $urandom_range(0, 3) != 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
